// File: rtl/disp_priority_scan_ctrl.sv
// disp_priority_scan_ctrl
//   Scans a 4-digit multiplexed 7-segment display and arbitrates it between a
//   high-priority (hi) and a low-priority (lo) requester. Ownership only changes
//   at frame boundaries so an image is never torn, and a newly granted source
//   keeps the display for at least HOLD_FRAMES frames.
// Ports
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   hi_req/hi_data/hi_dp  hi requester: request, 4 hex nibbles, 4 decimal points
//   lo_req/lo_data/lo_dp  lo requester: same layout
//   an                    active-low anodes, an[i]=0 lights digit i
//   sseg                  active-low cathodes {dp,g,f,e,d,c,b,a}
//   owner                 00 idle, 01 lo, 10 hi
//   frame_tick            one-cycle pulse in the cycle after each frame boundary

// hex_to_sseg: nibble + decimal point to active-low {dp,g..a}
module hex_to_sseg (
   input  logic [3:0] hex,
   input  logic       dp,
   output logic [7:0] sseg
);
   always_comb begin
      sseg[7] = ~dp;
      case (hex)
         4'h0: sseg[6:0] = 7'h40;
         4'h1: sseg[6:0] = 7'h79;
         4'h2: sseg[6:0] = 7'h24;
         4'h3: sseg[6:0] = 7'h30;
         4'h4: sseg[6:0] = 7'h19;
         4'h5: sseg[6:0] = 7'h12;
         4'h6: sseg[6:0] = 7'h02;
         4'h7: sseg[6:0] = 7'h78;
         4'h8: sseg[6:0] = 7'h00;
         4'h9: sseg[6:0] = 7'h10;
         4'ha: sseg[6:0] = 7'h08;
         4'hb: sseg[6:0] = 7'h03;
         4'hc: sseg[6:0] = 7'h46;
         4'hd: sseg[6:0] = 7'h21;
         4'he: sseg[6:0] = 7'h06;
         default: sseg[6:0] = 7'h0e;
      endcase
   end
endmodule

module disp_priority_scan_ctrl #(
   parameter int unsigned DIGIT_TICKS = 65536,
   parameter int unsigned HOLD_FRAMES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        hi_req,
   input  logic [15:0] hi_data,
   input  logic [3:0]  hi_dp,
   input  logic        lo_req,
   input  logic [15:0] lo_data,
   input  logic [3:0]  lo_dp,
   output logic [3:0]  an,
   output logic [7:0]  sseg,
   output logic [1:0]  owner,
   output logic        frame_tick
);
   localparam int unsigned TW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
   localparam int unsigned HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(DIGIT_TICKS - 1);
   localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_FRAMES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LO   = 2'b01,
      ST_HI   = 2'b10
   } state_t;

   state_t         state, state_d;
   logic [TW-1:0]  tick;
   logic [1:0]     digit;
   logic [HW-1:0]  hold, hold_d;
   logic [15:0]    snap_data, snap_data_d;
   logic [3:0]     snap_dp, snap_dp_d;
   logic           frame_end;
   logic [3:0]     cur_nib;
   logic           cur_dp;
   logic [7:0]     dec_sseg;

   assign frame_end = (tick == TICK_LAST) && (digit == 2'd3);

   // scan counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tick  <= '0;
         digit <= '0;
      end else if (tick == TICK_LAST) begin
         tick  <= '0;
         digit <= digit + 2'd1;
      end else begin
         tick <= tick + 1'b1;
      end
   end

   // arbitration state, hold counter and snapshot
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         hold      <= '0;
         snap_data <= '0;
         snap_dp   <= '0;
      end else begin
         state     <= state_d;
         hold      <= hold_d;
         snap_data <= snap_data_d;
         snap_dp   <= snap_dp_d;
      end
   end

   always_comb begin
      state_d     = state;
      hold_d      = hold;
      snap_data_d = snap_data;
      snap_dp_d   = snap_dp;
      if (frame_end) begin
         case (state)
            ST_IDLE: begin
               if (hi_req)      state_d = ST_HI;
               else if (lo_req) state_d = ST_LO;
            end
            ST_LO: begin
               // hi preempts lo even while lo's hold is still running
               if (hi_req)                      state_d = ST_HI;
               else if (hold == '0 && !lo_req)  state_d = ST_IDLE;
            end
            ST_HI: begin
               if (hold == '0 && !hi_req) state_d = lo_req ? ST_LO : ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase

         if (state_d == ST_IDLE)     hold_d = '0;
         else if (state_d != state)  hold_d = HOLD_INIT;
         else if (hold != '0)        hold_d = hold - 1'b1;

         // a held source whose request has dropped keeps its last image
         if (state_d == ST_HI && hi_req) begin
            snap_data_d = hi_data;
            snap_dp_d   = hi_dp;
         end else if (state_d == ST_LO && lo_req) begin
            snap_data_d = lo_data;
            snap_dp_d   = lo_dp;
         end
      end
   end

   assign cur_nib = snap_data[{digit, 2'b00} +: 4];
   assign cur_dp  = snap_dp[digit];

   hex_to_sseg u_dec (
      .hex  (cur_nib),
      .dp   (cur_dp),
      .sseg (dec_sseg)
   );

   // registered pin drivers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         an         <= '1;
         sseg       <= '1;
         owner      <= 2'b00;
         frame_tick <= 1'b0;
      end else begin
         if (state == ST_IDLE) begin
            an   <= '1;
            sseg <= '1;
         end else begin
            an   <= ~(4'b0001 << digit);
            sseg <= dec_sseg;
         end
         owner      <= state_d;
         frame_tick <= frame_end;
      end
   end
endmodule

// File: tb/tb_disp_priority_scan_ctrl.sv
// tb_disp_priority_scan_ctrl
//   Cycle-level reference model of the scan controller feeding a scoreboard
//   queue; each clock the expected pin values are pushed, then popped and
//   compared against the DUT one time unit after the rising edge.
module tb_disp_priority_scan_ctrl;
   localparam int DT = 4;
   localparam int HF = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        hi_req = 1'b0, lo_req = 1'b0;
   logic [15:0] hi_data = '0, lo_data = '0;
   logic [3:0]  hi_dp = '0, lo_dp = '0;
   logic [3:0]  an;
   logic [7:0]  sseg;
   logic [1:0]  owner;
   logic        frame_tick;

   always #5 clk = ~clk;

   disp_priority_scan_ctrl #(.DIGIT_TICKS(DT), .HOLD_FRAMES(HF)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .hi_req     (hi_req),
      .hi_data    (hi_data),
      .hi_dp      (hi_dp),
      .lo_req     (lo_req),
      .lo_data    (lo_data),
      .lo_dp      (lo_dp),
      .an         (an),
      .sseg       (sseg),
      .owner      (owner),
      .frame_tick (frame_tick)
   );

   typedef struct packed {
      logic [3:0] an;
      logic [7:0] sseg;
      logic [1:0] owner;
      logic       ft;
   } exp_t;

   exp_t sb[$];
   exp_t last_e;
   int   vectors = 0;
   int   miscompares = 0;

   // active-low g..a patterns for 0..F
   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};

   int          m_tick, m_digit, m_state, m_hold;
   logic [15:0] m_sd;
   logic [3:0]  m_sdp;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_tick = 0; m_digit = 0; m_state = 0; m_hold = 0;
      m_sd = '0; m_sdp = '0;
   endtask

   function automatic bit model_frame_end();
      return (m_tick == DT-1) && (m_digit == 3);
   endfunction

   task automatic step();
      exp_t e;
      exp_t got;
      int ns;
      bit f;
      logic [3:0] nib;
      f = model_frame_end();
      if (m_state == 0) begin
         e.an = 4'hF;
         e.sseg = 8'hFF;
      end else begin
         e.an = 4'hF ^ (4'h1 << m_digit);
         nib = m_sd[m_digit*4 +: 4];
         e.sseg = {~m_sdp[m_digit], seg_tab[nib]};
      end
      ns = m_state;
      if (f) begin
         case (m_state)
            0: ns = hi_req ? 2 : (lo_req ? 1 : 0);
            1: ns = hi_req ? 2 : ((m_hold == 0 && !lo_req) ? 0 : 1);
            default: ns = (m_hold == 0 && !hi_req) ? (lo_req ? 1 : 0) : 2;
         endcase
         if (ns == 0) m_hold = 0;
         else if (ns != m_state) m_hold = HF - 1;
         else if (m_hold > 0) m_hold--;
         if (ns == 2 && hi_req) begin m_sd = hi_data; m_sdp = hi_dp; end
         else if (ns == 1 && lo_req) begin m_sd = lo_data; m_sdp = lo_dp; end
         m_state = ns;
      end
      e.owner = 2'(m_state);
      e.ft = f;
      if (m_tick == DT-1) begin
         m_tick = 0;
         m_digit = (m_digit + 1) % 4;
      end else begin
         m_tick++;
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      last_e = got;
      check("an", an, got.an);
      check("sseg", sseg, got.sseg);
      check("owner", owner, got.owner);
      check("frame_tick", frame_tick, got.ft);
      check("an_onehot", ($countones(~an) <= 1), 1);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic goto_frame_end();
      for (int g = 0; g < 4*DT*2 && !model_frame_end(); g++) step();
      check("frame_end_reached", model_frame_end(), 1);
   endtask

   initial begin
      int hi_cnt;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_an", an, 4'hF);
      check("rst_sseg", sseg, 8'hFF);
      check("rst_owner", owner, 2'b00);
      check("rst_ftick", frame_tick, 1'b0);
      #4 reset_n = 1'b1;

      // idle with no requests
      run(20);

      // lo owns the display
      lo_req = 1'b1; lo_data = 16'h1234; lo_dp = 4'b0001;
      for (int i = 0; i < 40; i++) begin
         step();
         if (last_e.owner == 2'b01 && last_e.an == 4'b1110) check("lo_dig0", sseg, 8'h19);
         if (last_e.owner == 2'b01 && last_e.an == 4'b0111) check("lo_dig3", sseg, 8'hF9);
      end

      // hi raised mid-frame preempts at the next boundary
      run(5);
      hi_req = 1'b1; hi_data = 16'hABCD; hi_dp = 4'b0000;
      for (int i = 0; i < 40; i++) begin
         step();
         if (last_e.owner == 2'b10 && last_e.an == 4'b1110) check("hi_dig0", sseg, 8'hA1);
      end
      hi_req = 1'b0;
      run(40);

      // async reset mid-frame, no clock edge
      run(6);
      #2 reset_n = 1'b0;
      #1;
      check("async_an", an, 4'hF);
      check("async_sseg", sseg, 8'hFF);
      check("async_owner", owner, 2'b00);
      check("async_ftick", frame_tick, 1'b0);
      model_reset();
      lo_req = 1'b0;
      #1 reset_n = 1'b1;
      run(20);

      // hi requested only in the boundary cycle: held two frames with latched image
      goto_frame_end();
      hi_req = 1'b1; hi_data = 16'h5A0F; hi_dp = 4'b0000;
      hi_cnt = 0;
      step();
      if (owner == 2'b10) hi_cnt++;
      hi_req = 1'b0; hi_data = 16'h0000;
      for (int i = 0; i < 40; i++) begin
         step();
         if (owner == 2'b10) hi_cnt++;
         if (last_e.owner == 2'b10 && last_e.an == 4'b1110) check("latched_dig0", sseg, 8'h8E);
      end
      check("hi_hold_cycles", hi_cnt, 32);
      check("after_hold_idle", owner, 2'b00);

      // same, with lo waiting: falls to lo
      goto_frame_end();
      hi_req = 1'b1; hi_data = 16'h9876; hi_dp = 4'b1000;
      lo_req = 1'b1; lo_data = 16'hCAFE; lo_dp = 4'b0010;
      step();
      hi_req = 1'b0;
      run(40);
      check("after_hold_lo", owner, 2'b01);

      // back to idle, then both rise together
      lo_req = 1'b0;
      run(64);
      hi_req = 1'b1; lo_req = 1'b1;
      hi_data = 16'h0F1E; lo_data = 16'h2D3C;
      run(20);
      lo_req = 1'b0;
      run(20);
      hi_req = 1'b0;
      run(40);
      check("both_end_idle", owner, 2'b00);

      // randomized request traffic
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) == 0) hi_req = ~hi_req;
         if ($urandom_range(0, 7) == 0) lo_req = ~lo_req;
         if (i % 7 == 0) begin
            hi_data = 16'($urandom); lo_data = 16'($urandom);
            hi_dp = 4'($urandom); lo_dp = 4'($urandom);
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
